// File: rtl/fnd_scan_sched.sv
// -----------------------------------------------------------------------------
// fnd_scan_sched
//   Time-multiplexing scheduler for the shared 7-segment bus. Shares
//   o_seg/o_seg_dp among up to DIGITS common nodes. Only digits enabled in
//   i_digit_mask are scanned. An all-off blanking gap precedes every digit
//   slot to suppress ghosting. Digits flagged in i_blink are blanked on
//   alternate groups of BLINK_FRAMES frames.
//
//   Optional feature: define FND_SCAN_DIM_EN to add input i_dim. While i_dim
//   is high, a digit's common is released after the first half of its ON
//   slot. Slot timing is unchanged, so the display runs at half brightness.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   i_en           in   1 = scanning enabled
//   i_seg          in   encoded segments, digit k at [7k+6:7k], {a..g}
//   i_dp           in   decimal point per digit
//   i_digit_mask   in   1 = digit participates in the scan
//   i_blink        in   1 = digit blinks
//   o_seg          out  segment bus
//   o_seg_dp       out  decimal point
//   o_seg_enb      out  common enables, active-low, at most one low
//   o_frame_start  out  1-clk pulse on ON entry of the lowest enabled digit
//   i_dim          in   (FND_SCAN_DIM_EN only) 1 = half-brightness drive
// -----------------------------------------------------------------------------
module fnd_scan_sched #(
    parameter int DIGITS       = 6,
    parameter int TICK_DIV     = 5000,
    parameter int BLANK_TICKS  = 1,
    parameter int ON_TICKS     = 8,
    parameter int BLINK_FRAMES = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic [7*DIGITS-1:0]   i_seg,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [DIGITS-1:0]     i_digit_mask,
    input  logic [DIGITS-1:0]     i_blink,
    output logic [6:0]            o_seg,
    output logic                  o_seg_dp,
    output logic [DIGITS-1:0]     o_seg_enb,
    output logic                  o_frame_start
`ifdef FND_SCAN_DIM_EN
    ,
    input  logic                  i_dim
`endif
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int MAX_T = (BLANK_TICKS > ON_TICKS) ? BLANK_TICKS : ON_TICKS;
    localparam int CNT_W = $clog2(MAX_T);
    localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0]  ON_LAST    = CNT_W'(ON_TICKS - 1);
    localparam logic [FR_W-1:0]   FR_LAST    = FR_W'(BLINK_FRAMES - 1);
    localparam logic [DIGITS-1:0] ENB_OFF    = {DIGITS{1'b1}};
`ifdef FND_SCAN_DIM_EN
    // Last tick index of the bright half of an ON slot.
    localparam logic [CNT_W-1:0]  DIM_LAST   = CNT_W'(ON_TICKS / 2 - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [DIGITS-1:0] mask);
        logic [IDX_W-1:0] res;
        res = {IDX_W{1'b0}};
        for (int j = DIGITS - 1; j >= 0; j--) begin
            if (mask[j]) begin
                res = IDX_W'(j);
            end
        end
        return res;
    endfunction

    // Next set bit strictly after idx, wrapping around; idx itself when it
    // is the only set bit.
    function automatic logic [IDX_W-1:0] next_set(input logic [DIGITS-1:0] mask,
                                                  input logic [IDX_W-1:0]  idx);
        logic             found_hi;
        logic             found_lo;
        logic [IDX_W-1:0] res_hi;
        logic [IDX_W-1:0] res_lo;
        found_hi = 1'b0;
        found_lo = 1'b0;
        res_hi   = idx;
        res_lo   = idx;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            if (mask[j] && (IDX_W'(j) > idx)) begin
                found_hi = 1'b1;
                res_hi   = IDX_W'(j);
            end
            if (mask[j] && (IDX_W'(j) <= idx)) begin
                found_lo = 1'b1;
                res_lo   = IDX_W'(j);
            end
        end
        return found_hi ? res_hi : (found_lo ? res_lo : idx);
    endfunction

    // Active-low common pattern with only digit idx driven.
    function automatic logic [DIGITS-1:0] enb_for(input logic [IDX_W-1:0] idx);
        logic [DIGITS-1:0] res;
        res = {DIGITS{1'b1}};
        for (int j = 0; j < DIGITS; j++) begin
            if (IDX_W'(j) == idx) begin
                res[j] = 1'b0;
            end
        end
        return res;
    endfunction

    // Segment slice of digit idx.
    function automatic logic [6:0] seg_at(input logic [7*DIGITS-1:0] vec,
                                          input logic [IDX_W-1:0]    idx);
        logic [6:0] res;
        res = 7'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (IDX_W'(j) == idx) begin
                res = vec[7*j +: 7];
            end
        end
        return res;
    endfunction

    // Single bit of a per-digit vector.
    function automatic logic bit_at(input logic [DIGITS-1:0] vec,
                                    input logic [IDX_W-1:0]  idx);
        logic res;
        res = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (IDX_W'(j) == idx) begin
                res = vec[j];
            end
        end
        return res;
    endfunction

    state_t            state_r,  state_s;
    logic [IDX_W-1:0]  idx_r,    idx_s;
    logic [PRE_W-1:0]  presc_r,  presc_s;
    logic [CNT_W-1:0]  tcnt_r,   tcnt_s;
    logic [6:0]        seg_r,    seg_s;
    logic              dp_r,     dp_s;
    logic [DIGITS-1:0] enb_r,    enb_s;
    logic              fs_r,     fs_s;
    logic [FR_W-1:0]   fcnt_r,   fcnt_s;
    logic              phase_r,  phase_s;

    logic              tick_s;
    logic              mask_any_s;
    logic [IDX_W-1:0]  cur_lowest_s;
    logic              blank_dig_s;
    logic [6:0]        cap_seg_s;
    logic              cap_dp_s;

    // Decode helpers shared by the next-state logic.
    always_comb begin
        tick_s       = (presc_r == PRE_LAST);
        mask_any_s   = (i_digit_mask != {DIGITS{1'b0}});
        cur_lowest_s = lowest_set(i_digit_mask);
        blank_dig_s  = phase_r & bit_at(i_blink, idx_r);
        cap_seg_s    = seg_at(i_seg, idx_r);
        cap_dp_s     = bit_at(i_dp, idx_r);
    end

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        presc_s = presc_r;
        tcnt_s  = tcnt_r;
        seg_s   = seg_r;
        dp_s    = dp_r;
        enb_s   = enb_r;
        fs_s    = 1'b0;
        fcnt_s  = fcnt_r;
        phase_s = phase_r;

        if (!i_en) begin
            // Disable wins in every state; blink bookkeeping is retained.
            state_s = ST_IDLE;
            presc_s = {PRE_W{1'b0}};
            tcnt_s  = {CNT_W{1'b0}};
            seg_s   = 7'b0;
            dp_s    = 1'b0;
            enb_s   = ENB_OFF;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    presc_s = {PRE_W{1'b0}};
                    tcnt_s  = {CNT_W{1'b0}};
                    seg_s   = 7'b0;
                    dp_s    = 1'b0;
                    enb_s   = ENB_OFF;
                    if (mask_any_s) begin
                        state_s = ST_BLANK;
                        idx_s   = cur_lowest_s;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end

                ST_BLANK: begin
                    if (tick_s) begin
                        presc_s = {PRE_W{1'b0}};
                        if (tcnt_r == BLANK_LAST) begin
                            // Snapshot the digit; inputs are ignored for the slot.
                            state_s = ST_ON;
                            tcnt_s  = {CNT_W{1'b0}};
                            seg_s   = blank_dig_s ? 7'b0 : cap_seg_s;
                            dp_s    = blank_dig_s ? 1'b0 : cap_dp_s;
                            enb_s   = enb_for(idx_r);
                            if (mask_any_s && (idx_r == cur_lowest_s)) begin
                                fs_s = 1'b1;
                                if (fcnt_r == FR_LAST) begin
                                    fcnt_s  = {FR_W{1'b0}};
                                    phase_s = ~phase_r;
                                end else begin
                                    fcnt_s  = fcnt_r + 1'b1;
                                end
                            end else begin
                                fs_s = 1'b0;
                            end
                        end else begin
                            tcnt_s = tcnt_r + 1'b1;
                        end
                    end else begin
                        presc_s = presc_r + 1'b1;
                    end
                end

                ST_ON: begin
                    if (tick_s) begin
                        presc_s = {PRE_W{1'b0}};
                        if (tcnt_r == ON_LAST) begin
                            tcnt_s = {CNT_W{1'b0}};
                            seg_s  = 7'b0;
                            dp_s   = 1'b0;
                            enb_s  = ENB_OFF;
                            // Mask is sampled here, so a digit cleared during its
                            // own slot finishes the slot and is then skipped.
                            if (mask_any_s) begin
                                state_s = ST_BLANK;
                                idx_s   = next_set(i_digit_mask, idx_r);
                            end else begin
                                state_s = ST_IDLE;
                            end
                        end else begin
                            tcnt_s = tcnt_r + 1'b1;
`ifdef FND_SCAN_DIM_EN
                            if (i_dim && (tcnt_r >= DIM_LAST)) begin
                                enb_s = ENB_OFF;
                            end else begin
                                enb_s = enb_for(idx_r);
                            end
`else
                            enb_s = enb_r;
`endif
                        end
                    end else begin
                        presc_s = presc_r + 1'b1;
                    end
                end

                default: begin
                    state_s = ST_IDLE;
                    presc_s = {PRE_W{1'b0}};
                    tcnt_s  = {CNT_W{1'b0}};
                    seg_s   = 7'b0;
                    dp_s    = 1'b0;
                    enb_s   = ENB_OFF;
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            presc_r <= {PRE_W{1'b0}};
            tcnt_r  <= {CNT_W{1'b0}};
            seg_r   <= 7'b0;
            dp_r    <= 1'b0;
            enb_r   <= ENB_OFF;
            fs_r    <= 1'b0;
            fcnt_r  <= {FR_W{1'b0}};
            phase_r <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            presc_r <= presc_s;
            tcnt_r  <= tcnt_s;
            seg_r   <= seg_s;
            dp_r    <= dp_s;
            enb_r   <= enb_s;
            fs_r    <= fs_s;
            fcnt_r  <= fcnt_s;
            phase_r <= phase_s;
        end
    end

    assign o_seg         = seg_r;
    assign o_seg_dp      = dp_r;
    assign o_seg_enb     = enb_r;
    assign o_frame_start = fs_r;

endmodule
